// File: rtl/timer_seq_ctrl.sv
// Period-table sequencer driving an external timer through IDLE/LOAD/RUN slots.
// Optional irq/irq_clr ports are enabled by defining TIMER_SEQ_CTRL_IRQ_EN.
module timer_seq_ctrl #(
  parameter int VAL_W   = 10,
  parameter int N_SLOTS = 4,
  localparam int AW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [VAL_W-1:0] cfg_wdata,
  input  logic [AW-1:0]    last_slot,
  input  logic             periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             tmr_done,
  output logic             tmr_enable,
  output logic             tmr_clear,
  output logic [VAL_W-1:0] tmr_final_value,
  output logic             busy,
  output logic [AW-1:0]    cur_slot,
  output logic             slot_done,
  output logic             seq_done,
  output logic             err
`ifdef TIMER_SEQ_CTRL_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state, state_n;
  logic [VAL_W-1:0] tbl [N_SLOTS];
  logic [AW-1:0]    last_q, last_n, slot_n;
  logic             per_q, per_n;
  logic             en_n, clr_n, sd_n, qd_n, err_n;
  logic [VAL_W-1:0] fv_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < unsigned'(N_SLOTS); i++) tbl[i] <= '0;
    end else if (state == IDLE && cfg_we) begin
      tbl[cfg_addr] <= cfg_wdata;
    end
  end

  // Outputs are registered copies of next-cycle values, so each reflects the state it is shown in.
  always_comb begin
    state_n = state;
    slot_n  = cur_slot;
    last_n  = last_q;
    per_n   = per_q;
    en_n    = 1'b0;
    clr_n   = 1'b0;
    fv_n    = tmr_final_value;
    sd_n    = 1'b0;
    qd_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = LOAD;
          slot_n  = '0;
          last_n  = last_slot;
          per_n   = periodic;
        end
      end
      LOAD: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tbl[cur_slot] == '0) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          state_n = RUN;
          en_n    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tmr_done) begin
          sd_n = 1'b1;
          if (cur_slot != last_q) begin
            slot_n  = cur_slot + AW'(1);
            state_n = LOAD;
          end else if (per_q) begin
            slot_n  = '0;
            state_n = LOAD;
          end else begin
            qd_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          en_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == LOAD) begin
      clr_n = 1'b1;
      fv_n  = tbl[slot_n];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cur_slot        <= '0;
      last_q          <= '0;
      per_q           <= 1'b0;
      tmr_enable      <= 1'b0;
      tmr_clear       <= 1'b0;
      tmr_final_value <= '0;
      busy            <= 1'b0;
      slot_done       <= 1'b0;
      seq_done        <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_n;
      cur_slot        <= slot_n;
      last_q          <= last_n;
      per_q           <= per_n;
      tmr_enable      <= en_n;
      tmr_clear       <= clr_n;
      tmr_final_value <= fv_n;
      busy            <= (state_n != IDLE);
      slot_done       <= sd_n;
      seq_done        <= qd_n;
      err             <= err_n;
    end
  end

`ifdef TIMER_SEQ_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             irq <= 1'b0;
    else if (seq_done || err) irq <= 1'b1;
    else if (irq_clr)         irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: cycle model of the sequencing rules plus directed scenarios.
module tb_timer_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [9:0] cfg_wdata = '0;
  logic [1:0] last_slot = '0;
  logic       periodic = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tmr_done = 1'b0;
  logic       tmr_enable, tmr_clear, busy, slot_done, seq_done, err;
  logic [9:0] tmr_final_value;
  logic [1:0] cur_slot;
  logic       irq_clr = 1'b0;
  logic       irq;

  timer_seq_ctrl #(.VAL_W(10), .N_SLOTS(4)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .last_slot(last_slot), .periodic(periodic),
    .start(start), .stop(stop), .tmr_done(tmr_done), .tmr_enable(tmr_enable),
    .tmr_clear(tmr_clear), .tmr_final_value(tmr_final_value), .busy(busy),
    .cur_slot(cur_slot), .slot_done(slot_done), .seq_done(seq_done), .err(err)
`ifdef TIMER_SEQ_CTRL_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

`ifndef TIMER_SEQ_CTRL_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  // Model: sequence position as plain integers, advanced by the rules of the block.
  int m_tbl [4];
  bit m_act, m_ld, m_per;
  int m_slot, m_last;
  int e_fv, e_slot;
  bit e_en, e_clr, e_busy, e_sd, e_qd, e_err, e_irq, irq_set;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (m_tbl[i]) m_tbl[i] = 0;
      m_act = 0; m_ld = 0; m_per = 0; m_slot = 0; m_last = 0;
      e_fv = 0; e_slot = 0; e_en = 0; e_clr = 0; e_busy = 0;
      e_sd = 0; e_qd = 0; e_err = 0; e_irq = 0;
    end else begin
      irq_set = e_qd | e_err;
      e_sd = 0; e_qd = 0; e_err = 0;
      if (!m_act) begin
        if (start && !stop) begin
          m_act = 1; m_ld = 1; m_slot = 0; m_last = int'(last_slot);
          m_per = periodic; e_fv = m_tbl[0];
        end
        if (cfg_we) m_tbl[cfg_addr] = int'(cfg_wdata);
      end else if (stop) begin
        m_act = 0;
      end else if (m_ld) begin
        if (m_tbl[m_slot] == 0) begin m_act = 0; e_err = 1; end
        else m_ld = 0;
      end else if (tmr_done) begin
        e_sd = 1;
        if (m_slot == m_last && !m_per) begin
          e_qd = 1; m_act = 0;
        end else begin
          m_slot = (m_slot == m_last) ? 0 : m_slot + 1;
          m_ld = 1; e_fv = m_tbl[m_slot];
        end
      end
      e_busy = m_act;
      e_en   = m_act && !m_ld;
      e_clr  = m_act && m_ld;
      e_slot = m_slot;
`ifdef TIMER_SEQ_CTRL_IRQ_EN
      if (irq_set) e_irq = 1;
      else if (irq_clr) e_irq = 0;
`endif
    end
  end

  int checks = 0;
  int errors = 0;
  int sd_cnt = 0, qd_cnt = 0, err_cnt = 0, ld_cnt = 0;
  logic [31:0] hist = '0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_en();
    int n = 0;
    while (tmr_enable !== 1'b1 && n < 20) begin tick(); n++; end
    chk("en_wait", tmr_enable, 1);
  endtask

  task automatic run_slot();
    wait_en();
    tick(2);
    tmr_done = 1; tick(); tmr_done = 0;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1; cfg_addr = 2'(a); cfg_wdata = 10'(d); tick(); cfg_we = 0;
  endtask

  task automatic go(input int ls, input bit per);
    last_slot = 2'(ls); periodic = per; start = 1; tick(); start = 0;
  endtask

  task automatic clr_irq();
    irq_clr = 1; tick(); irq_clr = 0;
  endtask

  int sd0, qd0, er0, ld0;
  task automatic snap();
    sd0 = sd_cnt; qd0 = qd_cnt; er0 = err_cnt; ld0 = ld_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (cmp_on) begin
          chk("cmp_en", tmr_enable, e_en);
          chk("cmp_clr", tmr_clear, e_clr);
          chk("cmp_fv", tmr_final_value, e_fv);
          chk("cmp_busy", busy, e_busy);
          chk("cmp_slot", cur_slot, e_slot);
          chk("cmp_sd", slot_done, e_sd);
          chk("cmp_qd", seq_done, e_qd);
          chk("cmp_err", err, e_err);
          chk("cmp_irq", irq, e_irq);
          if (slot_done) sd_cnt++;
          if (seq_done) qd_cnt++;
          if (err) err_cnt++;
          if (tmr_clear) begin hist = {hist[27:0], tmr_final_value[3:0]}; ld_cnt++; end
        end
      end
    join_none

    tick(2);
    cmp_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_fv", tmr_final_value, 0);
    reset_n = 1;
    tick();
    wr(0, 5); wr(1, 3); wr(2, 7); wr(3, 2);

    // one-shot 0..2
    snap(); go(2, 0);
    repeat (3) run_slot();
    tick(2);
    chk("a_loads", ld_cnt - ld0, 3);
    chk("a_hist", hist[11:0], 'h537);
    chk("a_sd", sd_cnt - sd0, 3);
    chk("a_qd", qd_cnt - qd0, 1);
    chk("a_busy", busy, 0);
    chk("a_slot_hold", cur_slot, 2);
`ifdef TIMER_SEQ_CTRL_IRQ_EN
    chk("a_irq", irq, 1);
    clr_irq();
    chk("a_irq_clr", irq, 0);
`endif

    // periodic 0,1 then stop in RUN
    snap(); go(1, 1);
    repeat (5) run_slot();
    wait_en();
    chk("b_hist", hist[23:0], 'h535353);
    chk("b_qd", qd_cnt - qd0, 0);
    stop = 1; tick(); stop = 0;
    chk("b_stop_busy", busy, 0);
    chk("b_stop_en", tmr_enable, 0);
    chk("b_sd", sd_cnt - sd0, 5);

    // start/cfg_we ignored in RUN; stop beats tmr_done
    snap(); go(2, 0);
    wait_en();
    cfg_we = 1; cfg_addr = 2; cfg_wdata = 9; start = 1; tick();
    cfg_we = 0; start = 0; tick();
    tmr_done = 1; stop = 1; tick(); tmr_done = 0; stop = 0;
    chk("c_busy", busy, 0);
    chk("c_sd", sd_cnt - sd0, 0);
    tick();
    snap(); go(2, 0);
    repeat (3) run_slot();
    tick(2);
    chk("c_hist", hist[11:0], 'h537);
`ifdef TIMER_SEQ_CTRL_IRQ_EN
    clr_irq();
`endif

    // zero period in slot 1
    wr(1, 0);
    snap(); go(3, 0);
    run_slot();
    tick(3);
    chk("d_err", err_cnt - er0, 1);
    chk("d_qd", qd_cnt - qd0, 0);
    chk("d_sd", sd_cnt - sd0, 1);
    chk("d_hist", hist[7:0], 'h50);
    chk("d_busy", busy, 0);
`ifdef TIMER_SEQ_CTRL_IRQ_EN
    tick(3);
    chk("d_irq_hold", irq, 1);
    clr_irq();
    chk("d_irq_clr", irq, 0);
`endif

    // reset mid-RUN, then zeroed table
    wr(1, 3);
    go(2, 0);
    wait_en();
    reset_n = 0; #1;
    chk("e_rst_en", tmr_enable, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_slot", cur_slot, 0);
    chk("e_rst_fv", tmr_final_value, 0);
    tick(); reset_n = 1; tick();
    snap(); go(0, 0);
    tick(3);
    chk("e_err", err_cnt - er0, 1);
    chk("e_hist", hist[3:0], 0);
    chk("e_sd", sd_cnt - sd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
